// File: rtl/op_entry_ctrl.sv
// Operand-entry / mode controller: key edges on tick edit two operands, launch a multiplier and show the product.
// Latency: key actions take effect on the tick clock edge; product latched MUL_LAT clocks after mul_start.
// Backpressure: none; keys are sampled on tick, S_WAIT ignores keys while the multiplier pipeline drains.
module op_entry_ctrl #(
  parameter int W          = 8,
  parameter int HOLD_TICKS = 100,
  parameter int MUL_LAT    = 4,
  parameter int NLED       = 8,
  parameter int LED_DIV    = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              key_mode,
  input  logic [1:0]        key_inc,
  input  logic [1:0]        key_dec,
  input  logic              key_ans,
  input  logic              key_auto,
  input  logic [2*W-1:0]    ans_in,
  output logic [W-1:0]      op_x,
  output logic [W-1:0]      op_y,
  output logic              mul_start,
  output logic [2*W-1:0]    result,
  output logic [1:0]        mode,
  output logic              busy,
  output logic [NLED-1:0]   led
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EDIT = 2'b01,
    S_WAIT = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int WW = $clog2(MUL_LAT + 1);
  localparam int DW = $clog2(LED_DIV + 1);
  localparam int IW = (NLED > 1) ? $clog2(NLED) : 1;

  // Bit positions inside the key history / rising-edge vectors.
  localparam int K_MODE = 0;
  localparam int K_INC0 = 1;
  localparam int K_INC1 = 2;
  localparam int K_DEC0 = 3;
  localparam int K_DEC1 = 4;
  localparam int K_ANS  = 5;

  state_t              state_q, state_d;
  logic [W-1:0]        op_x_q, op_x_d;
  logic [W-1:0]        op_y_q, op_y_d;
  logic [2*W-1:0]      result_q, result_d;
  logic                mul_start_q, mul_start_d;
  logic [NLED-1:0]     led_q, led_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [5:0]          hist_q, hist_d;

  logic [5:0]          key_now;
  logic [5:0]          rise;
  logic                auto_fire;

  // Rising-edge detection against the key history; history only advances on tick.
  always_comb begin
    key_now = {key_ans, key_dec[1], key_dec[0], key_inc[1], key_inc[0], key_mode};
    rise    = '0;
    hist_d  = hist_q;
    if (tick) begin
      rise   = key_now & ~hist_q;
      hist_d = key_now;
    end
  end

  // Hold-to-auto-step counter: counts held ticks in S_EDIT/S_SHOW and fires at HOLD_TICKS.
  always_comb begin
    hold_d    = hold_q;
    auto_fire = 1'b0;
    if (!key_auto) begin
      hold_d = '0;
    end else if (tick && (state_q == S_EDIT || state_q == S_SHOW)) begin
      if (hold_q + HW'(1) == HW'(HOLD_TICKS)) begin
        hold_d    = '0;
        auto_fire = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
    // Any state change restarts the hold window.
    if (state_d != state_q) begin
      hold_d = '0;
    end
  end

  // Main FSM: next state, operand edits, multiplier launch and product capture.
  always_comb begin
    state_d     = state_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    result_d    = result_q;
    mul_start_d = 1'b0;
    wait_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rise[K_MODE]) begin
          state_d = S_EDIT;
        end
      end
      S_EDIT: begin
        if (rise[K_MODE]) begin
          state_d = S_IDLE;
        end else if (rise[K_ANS] || auto_fire) begin
          state_d     = S_WAIT;
          mul_start_d = 1'b1;
        end else begin
          // Simultaneous inc and dec of one operand cancel out.
          unique case ({rise[K_INC0], rise[K_DEC0]})
            2'b10:   op_x_d = op_x_q + W'(1);
            2'b01:   op_x_d = op_x_q - W'(1);
            default: op_x_d = op_x_q;
          endcase
          unique case ({rise[K_INC1], rise[K_DEC1]})
            2'b10:   op_y_d = op_y_q + W'(1);
            2'b01:   op_y_d = op_y_q - W'(1);
            default: op_y_d = op_y_q;
          endcase
        end
      end
      S_WAIT: begin
        // mul_start is high in the first S_WAIT cycle; capture in the MUL_LAT-th.
        if (wait_q == WW'(MUL_LAT - 1)) begin
          result_d = ans_in;
          state_d  = S_SHOW;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_SHOW: begin
        if (rise[K_MODE]) begin
          state_d = S_IDLE;
        end else if (rise[K_ANS]) begin
          state_d = S_EDIT;
        end else if (auto_fire) begin
          op_x_d  = op_x_q + W'(1);
          op_y_d  = op_y_q + W'(1);
          state_d = S_EDIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Marquee: one walking low LED in S_IDLE, all dark elsewhere with divider/index cleared.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (state_d != S_IDLE) begin
      div_d = '0;
      idx_d = '0;
    end else if (tick && state_q == S_IDLE) begin
      if (div_q + DW'(1) == DW'(LED_DIV)) begin
        div_d = '0;
        idx_d = (idx_q == IW'(NLED - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    led_d = '1;
    for (int i = 0; i < NLED; i++) begin
      if (state_d == S_IDLE && idx_d == IW'(NLED - 1 - i)) begin
        led_d[i] = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_x_q      <= '0;
      op_y_q      <= '0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      led_q       <= '1;
      hold_q      <= '0;
      wait_q      <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      hist_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      result_q    <= result_d;
      mul_start_q <= mul_start_d;
      led_q       <= led_d;
      hold_q      <= hold_d;
      wait_q      <= wait_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      hist_q      <= hist_d;
    end
  end

  assign op_x      = op_x_q;
  assign op_y      = op_y_q;
  assign mul_start = mul_start_q;
  assign result    = result_q;
  assign mode      = state_q;
  assign busy      = (state_q == S_WAIT);
  assign led       = led_q;

endmodule

// File: tb/tb_op_entry_ctrl.sv
// Directed bench for op_entry_ctrl: mode walk, operand wrap, compute latency, auto step, marquee, reset abort.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
// Ticks are single-clock strobes separated by an idle clock.
module tb_op_entry_ctrl;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        key_mode;
  logic [1:0]  key_inc;
  logic [1:0]  key_dec;
  logic        key_ans;
  logic        key_auto;
  logic [15:0] ans_in;
  logic [7:0]  op_x;
  logic [7:0]  op_y;
  logic        mul_start;
  logic [15:0] result;
  logic [1:0]  mode;
  logic        busy;
  logic [7:0]  led;

  int compared;
  int mismatched;
  logic [7:0] exp_led [0:8];

  op_entry_ctrl #(
    .W(8), .HOLD_TICKS(100), .MUL_LAT(4), .NLED(8), .LED_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .key_ans(key_ans), .key_auto(key_auto), .ans_in(ans_in),
    .op_x(op_x), .op_y(op_y), .mul_start(mul_start), .result(result),
    .mode(mode), .busy(busy), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One idle clock, then a one-clock tick; returns just after the tick edge.
  task automatic step_tick();
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic tick_keys(input logic m, input logic [1:0] inc, input logic [1:0] dec, input logic a);
    key_mode = m;
    key_inc  = inc;
    key_dec  = dec;
    key_ans  = a;
    step_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (mode !== 2'b00) begin mismatched++; $display("FAIL rst_mode: got %0h want 0", mode); end
    compared++; if (op_x !== 8'h00 || op_y !== 8'h00) begin mismatched++; $display("FAIL rst_ops: got %0h/%0h want 0/0", op_x, op_y); end
    compared++; if (result !== 16'h0000) begin mismatched++; $display("FAIL rst_result: got %0h want 0", result); end
    compared++; if (mul_start !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rst_ms_busy: got %0b/%0b want 0/0", mul_start, busy); end
    compared++; if (led !== 8'hFF) begin mismatched++; $display("FAIL rst_led: got %0h want ff", led); end
    rst = 1'b0;
    @(posedge clk); #1;
    compared++; if (led !== 8'h7F) begin mismatched++; $display("FAIL idle_led0: got %0h want 7f", led); end
  endtask

  task automatic test_mode();
    tick_keys(1'b1, 2'b00, 2'b00, 1'b0);
    compared++; if (mode !== 2'b01) begin mismatched++; $display("FAIL mode_edit1: got %0h want 1", mode); end
    compared++; if (led !== 8'hFF) begin mismatched++; $display("FAIL edit_led: got %0h want ff", led); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    compared++; if (mode !== 2'b01) begin mismatched++; $display("FAIL mode_hold: got %0h want 1", mode); end
    tick_keys(1'b1, 2'b00, 2'b00, 1'b0);
    compared++; if (mode !== 2'b00) begin mismatched++; $display("FAIL mode_idle: got %0h want 0", mode); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b1, 2'b00, 2'b00, 1'b0);
    compared++; if (mode !== 2'b01) begin mismatched++; $display("FAIL mode_edit2: got %0h want 1", mode); end
    compared++; if (led !== 8'hFF) begin mismatched++; $display("FAIL edit_led2: got %0h want ff", led); end
    compared++; if (op_x !== 8'h00 || op_y !== 8'h00) begin mismatched++; $display("FAIL mode_ops: got %0h/%0h want 0/0", op_x, op_y); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_operands();
    tick_keys(1'b0, 2'b00, 2'b01, 1'b0);
    compared++; if (op_x !== 8'hFF) begin mismatched++; $display("FAIL dec_x_wrap: got %0h want ff", op_x); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b01, 2'b00, 1'b0);
    compared++; if (op_x !== 8'h00) begin mismatched++; $display("FAIL inc_x_wrap: got %0h want 0", op_x); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b00, 2'b10, 1'b0);
    compared++; if (op_y !== 8'hFF || op_x !== 8'h00) begin mismatched++; $display("FAIL dec_y_wrap: got %0h/%0h want 0/ff", op_x, op_y); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b01, 2'b01, 1'b0);
    compared++; if (op_x !== 8'h00) begin mismatched++; $display("FAIL inc_dec_cancel: got %0h want 0", op_x); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b11, 2'b00, 1'b0);
    compared++; if (op_x !== 8'h01 || op_y !== 8'h00) begin mismatched++; $display("FAIL inc_xy: got %0h/%0h want 1/0", op_x, op_y); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    // Level held across ticks is not a new edge.
    tick_keys(1'b0, 2'b01, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b01, 2'b00, 1'b0);
    compared++; if (op_x !== 8'h02) begin mismatched++; $display("FAIL held_level: got %0h want 2", op_x); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b00, 2'b01, 1'b0);
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_compute();
    int n_busy;
    int n_ms;
    for (int i = 0; i < 11; i++) begin
      tick_keys(1'b0, 2'b11, 2'b00, 1'b0);
      tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    end
    compared++; if (op_x !== 8'd12 || op_y !== 8'd11) begin mismatched++; $display("FAIL ops_12_11: got %0d/%0d want 12/11", op_x, op_y); end
    ans_in = 16'd132;
    tick_keys(1'b0, 2'b00, 2'b00, 1'b1);
    n_busy = 0;
    n_ms   = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) n_busy++;
      if (mul_start) n_ms++;
      @(posedge clk); #1;
    end
    compared++; if (n_busy != 4) begin mismatched++; $display("FAIL busy_len: got %0d want 4", n_busy); end
    compared++; if (n_ms != 1) begin mismatched++; $display("FAIL mul_start_len: got %0d want 1", n_ms); end
    compared++; if (mode !== 2'b11) begin mismatched++; $display("FAIL mode_show: got %0h want 3", mode); end
    compared++; if (result !== 16'd132) begin mismatched++; $display("FAIL result_132: got %0d want 132", result); end
    ans_in = 16'd999;
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    compared++; if (result !== 16'd132) begin mismatched++; $display("FAIL result_held: got %0d want 132", result); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b1);
    compared++; if (mode !== 2'b01) begin mismatched++; $display("FAIL show_to_edit: got %0h want 1", mode); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_auto();
    for (int i = 0; i < 8; i++) begin
      tick_keys(1'b0, 2'b00, 2'b11, 1'b0);
      tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    end
    tick_keys(1'b0, 2'b00, 2'b01, 1'b0);
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    compared++; if (op_x !== 8'd3 || op_y !== 8'd3) begin mismatched++; $display("FAIL ops_3_3: got %0d/%0d want 3/3", op_x, op_y); end
    ans_in   = 16'd9;
    key_auto = 1'b1;
    for (int i = 0; i < 99; i++) step_tick();
    compared++; if (mode !== 2'b01) begin mismatched++; $display("FAIL auto_early: got %0h want 1", mode); end
    step_tick();
    compared++; if (mode !== 2'b10 || mul_start !== 1'b1) begin mismatched++; $display("FAIL auto_launch: got mode %0h ms %0b want 2/1", mode, mul_start); end
    repeat (6) @(posedge clk);
    #1;
    compared++; if (mode !== 2'b11 || result !== 16'd9) begin mismatched++; $display("FAIL auto_show: got mode %0h res %0d want 3/9", mode, result); end
    for (int i = 0; i < 99; i++) step_tick();
    compared++; if (mode !== 2'b11) begin mismatched++; $display("FAIL auto_show_hold: got %0h want 3", mode); end
    step_tick();
    compared++; if (mode !== 2'b01 || op_x !== 8'd4 || op_y !== 8'd4) begin mismatched++; $display("FAIL auto_step: got mode %0h ops %0d/%0d want 1 4/4", mode, op_x, op_y); end
    key_auto = 1'b0;
    step_tick();
  endtask

  task automatic test_marquee_priority();
    exp_led = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7F};
    tick_keys(1'b1, 2'b00, 2'b00, 1'b1);
    compared++; if (mode !== 2'b00 || mul_start !== 1'b0) begin mismatched++; $display("FAIL prio_mode: got mode %0h ms %0b want 0/0", mode, mul_start); end
    compared++; if (led !== 8'h7F) begin mismatched++; $display("FAIL marquee_start: got %0h want 7f", led); end
    for (int k = 1; k <= 16; k++) begin
      tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
      compared++; if (led !== exp_led[k/2]) begin mismatched++; $display("FAIL marquee_t%0d: got %0h want %0h", k, led, exp_led[k/2]); end
    end
    tick_keys(1'b0, 2'b01, 2'b00, 1'b1);
    compared++; if (op_x !== 8'd4 || mode !== 2'b00) begin mismatched++; $display("FAIL idle_ignore: got op_x %0d mode %0h want 4/0", op_x, mode); end
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    tick_keys(1'b1, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b00, 2'b00, 1'b0);
    tick_keys(1'b0, 2'b00, 2'b00, 1'b1);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rw_busy: got %0b want 1", busy); end
    @(posedge clk); #1;
    rst     = 1'b1;
    key_ans = 1'b0;
    @(posedge clk); #1;
    compared++; if (mode !== 2'b00 || busy !== 1'b0 || mul_start !== 1'b0) begin mismatched++; $display("FAIL rw_ctrl: got mode %0h busy %0b ms %0b want 0/0/0", mode, busy, mul_start); end
    compared++; if (result !== 16'd0 || op_x !== 8'd0 || op_y !== 8'd0) begin mismatched++; $display("FAIL rw_data: got res %0d ops %0d/%0d want 0 0/0", result, op_x, op_y); end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    compared++; if (result !== 16'd0 || mode !== 2'b00) begin mismatched++; $display("FAIL rw_abort: got res %0d mode %0h want 0/0", result, mode); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    tick       = 1'b0;
    key_mode   = 1'b0;
    key_inc    = 2'b00;
    key_dec    = 2'b00;
    key_ans    = 1'b0;
    key_auto   = 1'b0;
    ans_in     = 16'd0;
    test_reset();
    test_mode();
    test_operands();
    test_compute();
    test_auto();
    test_marquee_priority();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
